// File: rtl/ext_bus_slv.sv
// External bus responder: turns single master transactions into one
// byte-enabled word access on a local memory port, with ACK/RESP strobes.
module ext_bus_slv #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bus_en_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [1:0]            bus_size_i,
  input  logic                  bus_we_i,
  input  logic [DATA_WIDTH-1:0] bus_data_recv,
  output logic [DATA_WIDTH-1:0] bus_data_drv,
  output logic                  bus_data_o_en,
  output logic                  slv_rdy_o,
  output logic                  err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rdy_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    WDATA0 = 3'd2,
    WDATA1 = 3'd3,
    MEM    = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  a_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        err_q;
  logic        req_err;
  logic        accept;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   calc_be = 4'b0001 << a;
      2'b01:   calc_be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   calc_be = 4'b1111;
      default: calc_be = 4'b0000;
    endcase
  endfunction

  function automatic logic calc_err(input logic [1:0] size, input logic [1:0] a);
    calc_err = (size == 2'b11) ||
               (size == 2'b01 && a[0]) ||
               (size == 2'b10 && a != 2'b00);
  endfunction

  // Right-align and zero-extend the addressed lanes of the memory word.
  function automatic logic [DATA_WIDTH-1:0] fmt_rdata(input logic [1:0] size,
                                                      input logic [1:0] a,
                                                      input logic [DATA_WIDTH-1:0] rdata);
    logic [DATA_WIDTH-1:0] sh_b;
    logic [DATA_WIDTH-1:0] sh_h;
    sh_b = rdata >> {a, 3'b000};
    sh_h = rdata >> {a[1], 4'b0000};
    case (size)
      2'b00:   fmt_rdata = {24'h0, sh_b[7:0]};
      2'b01:   fmt_rdata = {16'h0, sh_h[15:0]};
      2'b10:   fmt_rdata = rdata;
      default: fmt_rdata = '0;
    endcase
  endfunction

  assign accept  = (state == IDLE) && bus_en_i;
  assign req_err = calc_err(bus_size_i, bus_addr_i[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus_en_i) state_nxt = ACK;
      ACK: begin
        if (err_q)     state_nxt = RESP;
        else if (we_q) state_nxt = WDATA0;
        else           state_nxt = MEM;
      end
      WDATA0:  state_nxt = WDATA1;
      WDATA1:  state_nxt = MEM;
      MEM:     if (mem_rdy_i) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, write-lane shift and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q          <= 2'b00;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= 4'b0000;
      mem_wdata_o  <= '0;
      bus_data_drv <= '0;
    end else begin
      if (accept) begin
        a_q          <= bus_addr_i[1:0];
        size_q       <= bus_size_i;
        we_q         <= bus_we_i;
        err_q        <= req_err;
        mem_addr_o   <= {bus_addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem_be_o     <= req_err ? 4'b0000 : calc_be(bus_size_i, bus_addr_i[1:0]);
        bus_data_drv <= '0;
      end
      if (state == WDATA1)
        mem_wdata_o <= bus_data_recv << {a_q, 3'b000};
      if (state == MEM && mem_rdy_i && !we_q)
        bus_data_drv <= fmt_rdata(size_q, a_q, mem_rdata_i);
    end
  end

  assign slv_rdy_o     = (state == ACK) || (state == RESP);
  assign mem_en_o      = (state == MEM);
  assign mem_we_o      = (state == MEM) && we_q;
  assign err_o         = (state == RESP) && err_q;
  assign bus_data_o_en = (state == RESP) && !we_q && !err_q;

endmodule

// File: tb/tb_ext_bus_slv.sv
// Directed bench for ext_bus_slv: reset, read/write paths, wait states,
// rejected requests and back-to-back transfers.
module tb_ext_bus_slv;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        bus_en_i;
  logic [15:0] bus_addr_i;
  logic [1:0]  bus_size_i;
  logic        bus_we_i;
  logic [31:0] bus_data_recv;
  logic [31:0] bus_data_drv;
  logic        bus_data_o_en;
  logic        slv_rdy_o;
  logic        err_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rdy_i;

  int checks = 0;
  int errors = 0;
  int mem_acc;

  ext_bus_slv #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .bus_en_i(bus_en_i), .bus_addr_i(bus_addr_i), .bus_size_i(bus_size_i),
    .bus_we_i(bus_we_i), .bus_data_recv(bus_data_recv), .bus_data_drv(bus_data_drv),
    .bus_data_o_en(bus_data_o_en), .slv_rdy_o(slv_rdy_o), .err_o(err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_rdy_i(mem_rdy_i)
  );

  always #5 clk = ~clk;

  // Completed memory accesses, used to spot duplicates.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_acc <= 0;
    else if (mem_en_o && mem_rdy_i) mem_acc <= mem_acc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [15:0] addr, input logic [1:0] size, input logic we);
    bus_en_i   = 1'b1;
    bus_addr_i = addr;
    bus_size_i = size;
    bus_we_i   = we;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_en_i = 1'b0; bus_addr_i = '0; bus_size_i = '0; bus_we_i = 1'b0;
    bus_data_recv = '0; mem_rdata_i = '0; mem_rdy_i = 1'b0;
    step(); step();
    checks++;
    if ({slv_rdy_o, err_o, bus_data_o_en, mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, bus_data_drv} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b err=%b oen=%b men=%b mwe=%b be=%b addr=%h wd=%h rd=%h required all 0",
               slv_rdy_o, err_o, bus_data_o_en, mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, bus_data_drv);
    end
    reset_n = 1'b1;
    step(); step();
    checks++;
    if ({slv_rdy_o, mem_en_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got rdy/men/err=%b required 000", {slv_rdy_o, mem_en_o, err_o});
    end
  endtask

  task automatic test_word_read();
    mem_rdata_i = 32'hDEADBEEF; mem_rdy_i = 1'b1;
    start_req(16'h0010, 2'b10, 1'b0);        // cycle 1
    checks++;
    if (slv_rdy_o !== 1'b0) begin errors++; $display("FAIL wr_c1_rdy got %b required 0", slv_rdy_o); end
    step();                                  // cycle 2: ACK
    checks++;
    if ({slv_rdy_o, mem_en_o} !== 2'b10) begin errors++; $display("FAIL wr_c2_ack got rdy/men=%b required 10", {slv_rdy_o, mem_en_o}); end
    bus_en_i = 1'b0;
    step();                                  // cycle 3: MEM
    checks++;
    if ({slv_rdy_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o} !== {3'b010, 4'b1111, 16'h0010}) begin
      errors++; $display("FAIL wr_c3_mem got rdy=%b men=%b mwe=%b be=%b addr=%h required 0 1 0 1111 0010",
                         slv_rdy_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    step();                                  // cycle 4: RESP
    checks++;
    if ({slv_rdy_o, bus_data_o_en, err_o, mem_en_o, bus_data_drv} !== {4'b1100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_c4_resp got rdy=%b oen=%b err=%b men=%b data=%h required 1 1 0 0 deadbeef",
                         slv_rdy_o, bus_data_o_en, err_o, mem_en_o, bus_data_drv);
    end
    step();
    checks++;
    if ({slv_rdy_o, bus_data_o_en} !== 2'b00) begin errors++; $display("FAIL wr_c5_idle got %b required 00", {slv_rdy_o, bus_data_o_en}); end
  endtask

  task automatic test_byte_write();
    mem_rdy_i = 1'b1; bus_data_recv = 32'h0;
    start_req(16'h0013, 2'b00, 1'b1);        // cycle 1
    step();                                  // cycle 2: ACK
    bus_en_i = 1'b0;
    step();                                  // cycle 3: WDATA0
    bus_data_recv = 32'h000000A5;
    checks++;
    if ({slv_rdy_o, mem_en_o} !== 2'b00) begin errors++; $display("FAIL bw_c3 got rdy/men=%b required 00", {slv_rdy_o, mem_en_o}); end
    step();                                  // cycle 4: WDATA1
    checks++;
    if (mem_en_o !== 1'b0) begin errors++; $display("FAIL bw_c4_men got %b required 0", mem_en_o); end
    step();                                  // cycle 5: MEM
    bus_data_recv = 32'h0;
    checks++;
    if ({mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'b1000, 16'h0010, 32'hA5000000}) begin
      errors++; $display("FAIL bw_c5_mem got men=%b mwe=%b be=%b addr=%h wd=%h required 1 1 1000 0010 a5000000",
                         mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    step();                                  // cycle 6: RESP
    checks++;
    if ({slv_rdy_o, bus_data_o_en, err_o, mem_en_o} !== 4'b1000) begin
      errors++; $display("FAIL bw_c6_resp got rdy/oen/err/men=%b required 1000", {slv_rdy_o, bus_data_o_en, err_o, mem_en_o});
    end
    step();
  endtask

  task automatic test_half_read_wait();
    mem_rdata_i = 32'h12345678; mem_rdy_i = 1'b0;
    start_req(16'h0022, 2'b01, 1'b0);        // cycle 1
    step();                                  // cycle 2
    bus_en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin        // cycles 3..6: MEM
      step();
      if (i == 3) mem_rdy_i = 1'b1;
      checks++;
      if ({mem_en_o, slv_rdy_o, mem_be_o, mem_addr_o} !== {2'b10, 4'b1100, 16'h0020}) begin
        errors++; $display("FAIL hr_mem%0d got men=%b rdy=%b be=%b addr=%h required 1 0 1100 0020",
                           i, mem_en_o, slv_rdy_o, mem_be_o, mem_addr_o);
      end
    end
    step();                                  // cycle 7: RESP
    mem_rdy_i = 1'b0;
    checks++;
    if ({slv_rdy_o, bus_data_o_en, mem_en_o, bus_data_drv} !== {3'b110, 32'h00001234}) begin
      errors++; $display("FAIL hr_resp got rdy=%b oen=%b men=%b data=%h required 1 1 0 00001234",
                         slv_rdy_o, bus_data_o_en, mem_en_o, bus_data_drv);
    end
    step();
  endtask

  task automatic test_reject(input logic [15:0] addr, input logic [1:0] size, input logic we);
    int acc0;
    acc0 = mem_acc;
    mem_rdy_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    start_req(addr, size, we);               // cycle 1
    step();                                  // cycle 2: ACK
    bus_en_i = 1'b0;
    checks++;
    if ({slv_rdy_o, err_o, mem_en_o} !== 3'b100) begin
      errors++; $display("FAIL rej_ack_%h_%b got rdy/err/men=%b required 100", addr, size, {slv_rdy_o, err_o, mem_en_o});
    end
    step();                                  // cycle 3: RESP
    checks++;
    if ({slv_rdy_o, err_o, bus_data_o_en, mem_en_o, bus_data_drv} !== {4'b1100, 32'h0}) begin
      errors++; $display("FAIL rej_resp_%h_%b got rdy=%b err=%b oen=%b men=%b data=%h required 1 1 0 0 0",
                         addr, size, slv_rdy_o, err_o, bus_data_o_en, mem_en_o, bus_data_drv);
    end
    step();
    checks++;
    if ({err_o, slv_rdy_o, mem_en_o} !== 3'b000 || mem_acc != acc0) begin
      errors++; $display("FAIL rej_after_%h_%b got err/rdy/men=%b accesses=%0d required 000 accesses=%0d",
                         addr, size, {err_o, slv_rdy_o, mem_en_o}, mem_acc, acc0);
    end
  endtask

  task automatic test_back_to_back();
    int acc0;
    acc0 = mem_acc;
    mem_rdy_i = 1'b1; mem_rdata_i = 32'hCAFEBABE;
    start_req(16'h0006, 2'b01, 1'b1);        // write, cycle 1
    bus_data_recv = 32'h0000BEEF;
    step();                                  // cycle 2: ACK, bus_en_i still high
    bus_en_i = 1'b0;
    step(); step();                          // cycles 3, 4
    step();                                  // cycle 5: MEM
    checks++;
    if ({mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'b1100, 16'h0004, 32'hBEEF0000}) begin
      errors++; $display("FAIL b2b_wmem got men=%b mwe=%b be=%b addr=%h wd=%h required 1 1 1100 0004 beef0000",
                         mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    step();                                  // cycle 6: RESP
    checks++;
    if (slv_rdy_o !== 1'b1) begin errors++; $display("FAIL b2b_wresp got %b required 1", slv_rdy_o); end
    step();                                  // cycle 7: new read request
    start_req(16'h0101, 2'b00, 1'b0);
    step();                                  // ACK
    checks++;
    if ({slv_rdy_o, mem_en_o} !== 2'b10) begin errors++; $display("FAIL b2b_rack got rdy/men=%b required 10", {slv_rdy_o, mem_en_o}); end
    bus_en_i = 1'b0;
    step();                                  // MEM
    checks++;
    if ({mem_en_o, mem_we_o, mem_be_o, mem_addr_o} !== {2'b10, 4'b0010, 16'h0100}) begin
      errors++; $display("FAIL b2b_rmem got men=%b mwe=%b be=%b addr=%h required 1 0 0010 0100",
                         mem_en_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    step();                                  // RESP
    checks++;
    if ({slv_rdy_o, bus_data_o_en, bus_data_drv} !== {2'b11, 32'h000000BA}) begin
      errors++; $display("FAIL b2b_rresp got rdy=%b oen=%b data=%h required 1 1 000000ba",
                         slv_rdy_o, bus_data_o_en, bus_data_drv);
    end
    step();
    checks++;
    if (mem_acc - acc0 != 2) begin
      errors++; $display("FAIL b2b_access_count got %0d required 2", mem_acc - acc0);
    end
  endtask

  task automatic test_reset_mid_mem();
    mem_rdy_i = 1'b0; mem_rdata_i = 32'h11223344;
    start_req(16'h0040, 2'b10, 1'b0);
    step();
    bus_en_i = 1'b0;
    step(); step();                          // in MEM, stalled
    checks++;
    if (mem_en_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got men=%b required 1", mem_en_o); end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_en_o, slv_rdy_o, mem_addr_o, mem_be_o} !== '0) begin
      errors++; $display("FAIL rmid_async got men=%b rdy=%b addr=%h be=%b required all 0",
                         mem_en_o, slv_rdy_o, mem_addr_o, mem_be_o);
    end
    mem_rdy_i = 1'b1;
    step();
    reset_n = 1'b1;
    step(); step();
    checks++;
    if ({slv_rdy_o, mem_en_o, bus_data_o_en, bus_data_drv} !== '0) begin
      errors++; $display("FAIL rmid_after got rdy=%b men=%b oen=%b data=%h required all 0",
                         slv_rdy_o, mem_en_o, bus_data_o_en, bus_data_drv);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_read_wait();
    test_reject(16'h0001, 2'b10, 1'b0);
    test_reject(16'h0008, 2'b11, 1'b1);
    test_reject(16'h0003, 2'b01, 1'b0);
    test_back_to_back();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
